// File: rtl/fifo_stream_reader.sv
// Pops a 32-bit sync FIFO under buffer credit and replays words on a valid/ready stream; fifo_re->m_valid is 2 cycles.
// Backpressure holds fifo_re low once the skid buffer is committed; FIFO_RDR_STATS_EN adds rd_count/miss_count.
module fifo_stream_reader #(
   parameter int DW          = 32,
   parameter int BUF_DEPTH   = 2,
   parameter int BACKOFF_CYC = 4
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          en,
   output logic          fifo_re,
   input  logic [DW-1:0] fifo_dout,
   input  logic          fifo_empty,
   output logic          m_valid,
   output logic [DW-1:0] m_data,
   input  logic          m_ready,
   output logic          busy
`ifdef FIFO_RDR_STATS_EN
   ,
   output logic [31:0]   rd_count,
   output logic [15:0]   miss_count
`endif
);

   localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int OW = $clog2(BUF_DEPTH + 1);
   localparam int CW = $clog2(BACKOFF_CYC + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_BACKOFF
   } state_t;

   state_t          r_state;
   logic            r_pend;
   logic [CW-1:0]   r_cnt;
   logic [DW-1:0]   r_buf [BUF_DEPTH];
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [OW-1:0]   r_occ;

   logic            w_push;
   logic            w_miss;
   logic            w_pop;
   logic            w_credit_ok;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign w_push  = r_pend & ~fifo_empty;
   assign w_miss  = r_pend & fifo_empty;
   assign m_valid = (r_occ != '0);
   assign m_data  = r_buf[r_rd_ptr];
   assign w_pop   = m_valid & m_ready;

   // An in-flight pop already owns a slot, so the returning word can never overflow.
   assign w_credit_ok = (32'(r_occ) + 32'(r_pend)) < (32'(BUF_DEPTH) + 32'(w_pop));

   assign fifo_re = (r_state == S_READ) & en & w_credit_ok & ~w_miss;
   assign busy    = (r_state != S_IDLE) | r_pend | (r_occ != '0);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_pend  <= 1'b0;
      end else begin
         r_pend <= fifo_re;
         case (r_state)
            S_IDLE: begin
               if (en) r_state <= S_READ;
            end
            S_READ: begin
               if (w_miss) begin
                  r_state <= S_BACKOFF;
                  r_cnt   <= CW'(BACKOFF_CYC);
               end else if (!en) begin
                  r_state <= S_IDLE;
               end
            end
            S_BACKOFF: begin
               if (w_miss) begin
                  r_cnt <= CW'(BACKOFF_CYC);
               end else if (r_cnt == CW'(1)) begin
                  r_state <= en ? S_READ : S_IDLE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < BUF_DEPTH; i++) r_buf[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
      end else begin
         if (w_push) begin
            r_buf[r_wr_ptr] <= fifo_dout;
            r_wr_ptr        <= ptr_inc(r_wr_ptr);
         end
         if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
         case ({w_push, w_pop})
            2'b10:   r_occ <= r_occ + OW'(1);
            2'b01:   r_occ <= r_occ - OW'(1);
            default: r_occ <= r_occ;
         endcase
      end
   end

`ifdef FIFO_RDR_STATS_EN
   logic [31:0] r_rd_count;
   logic [15:0] r_miss_count;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rd_count   <= '0;
         r_miss_count <= '0;
      end else begin
         if (w_push) r_rd_count <= r_rd_count + 32'd1;
         if (w_miss && (r_miss_count != 16'hFFFF)) r_miss_count <= r_miss_count + 16'd1;
      end
   end

   assign rd_count   = r_rd_count;
   assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a queue-based source FIFO plus an in-order scoreboard of words accepted from it.
module tb_fifo_stream_reader;
   localparam int DW          = 32;
   localparam int BUF_DEPTH   = 2;
   localparam int BACKOFF_CYC = 4;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          en = 1'b0;
   logic          fifo_empty = 1'b1;
   logic [DW-1:0] fifo_dout = '0;
   logic          m_ready = 1'b0;
   logic          fifo_re;
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic          busy;
`ifdef FIFO_RDR_STATS_EN
   logic [31:0]   rd_count;
   logic [15:0]   miss_count;
`endif

   always #5 clk = ~clk;

   fifo_stream_reader #(.DW(DW), .BUF_DEPTH(BUF_DEPTH), .BACKOFF_CYC(BACKOFF_CYC)) dut (
      .clk(clk), .rstn(rstn), .en(en),
      .fifo_re(fifo_re), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
      .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .busy(busy)
`ifdef FIFO_RDR_STATS_EN
      , .rd_count(rd_count), .miss_count(miss_count)
`endif
   );

   int n_vec = 0, n_err = 0;
   int cyc = 0, s_cyc = 0, n_pop = 0, n_miss = 0, n_out = 0;
   logic [DW-1:0] src_q[$];
   logic [DW-1:0] exp_q[$];
   logic s_re, s_vld, s_rdy, s_busy;
   logic [DW-1:0] s_dat;
   logic p_stall = 1'b0;
   logic [DW-1:0] p_dat = '0;

   // Called at a negedge with this cycle's inputs set; returns at the next negedge with the FIFO response driven.
   task automatic cycle();
      logic [DW-1:0] w;
      logic [DW-1:0] e;
      #1;
      s_cyc = cyc; s_re = fifo_re; s_vld = m_valid; s_dat = m_data; s_rdy = m_ready; s_busy = busy;
      if (p_stall) begin
         n_vec++;
         if (s_vld !== 1'b1 || s_dat !== p_dat) begin
            n_err++;
            $display("FAIL stall_hold: valid=%0b data=%h, required valid=1 data=%h", s_vld, s_dat, p_dat);
         end
      end
      p_stall = s_vld && !s_rdy;
      p_dat   = s_dat;
      if (s_vld && s_rdy) begin
         n_vec++;
         n_out++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL stream_data: got %h, required no word (none accepted)", s_dat);
         end else begin
            e = exp_q.pop_front();
            if (s_dat !== e) begin
               n_err++;
               $display("FAIL stream_data: got %h, required %h", s_dat, e);
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
      if (s_re) begin
         n_pop++;
         if (src_q.size() > 0) begin
            w = src_q.pop_front();
            fifo_dout = w; fifo_empty = 1'b0;
            exp_q.push_back(w);
         end else begin
            fifo_dout = $urandom; fifo_empty = 1'b1;
            n_miss++;
         end
      end else begin
         fifo_dout = $urandom; fifo_empty = 1'($urandom_range(0, 1));
      end
      cyc++;
   endtask

   task automatic drain(input string tag);
      en = 1'b0; m_ready = 1'b1;
      for (int k = 0; k < 100; k++) begin
         cycle();
         if (!s_busy) break;
      end
      n_vec++;
      if (s_busy !== 1'b0) begin
         n_err++;
         $display("FAIL drain_%s: busy=%0b after 100 cycles, required 0", tag, s_busy);
      end
   endtask

   task automatic hard_reset();
      rstn = 1'b0;
      #1;
      exp_q.delete(); p_stall = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_reset();
      rstn = 1'b0; en = 1'b0; m_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      n_vec++; if (fifo_re !== 1'b0) begin n_err++; $display("FAIL reset_re: got %0b, required 0", fifo_re); end
      n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b, required 0", m_valid); end
      n_vec++; if (m_data !== '0) begin n_err++; $display("FAIL reset_data: got %h, required 0", m_data); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b, required 0", busy); end
`ifdef FIFO_RDR_STATS_EN
      n_vec++; if (rd_count !== 32'd0) begin n_err++; $display("FAIL reset_rd_count: got %0d, required 0", rd_count); end
      n_vec++; if (miss_count !== 16'd0) begin n_err++; $display("FAIL reset_miss_count: got %0d, required 0", miss_count); end
`endif
      @(negedge clk);
      rstn = 1'b1;
      cycle();
      n_vec++;
      if (s_re !== 1'b0 || s_busy !== 1'b0) begin
         n_err++; $display("FAIL idle_after_reset: re=%0b busy=%0b, required 0 0", s_re, s_busy);
      end
   endtask

   task automatic test_stream();
      int first_re = -1, first_vld = -1, first_hs = -1, last_hs = -1, o0;
      for (int i = 0; i < 8; i++) src_q.push_back(DW'(32'h10 + i));
      o0 = n_out; m_ready = 1'b1; en = 1'b1;
      for (int k = 0; k < 16; k++) begin
         cycle();
         if (s_re && first_re < 0) first_re = s_cyc;
         if (s_vld && first_vld < 0) first_vld = s_cyc;
         if (s_vld && s_rdy) begin
            if (first_hs < 0) first_hs = s_cyc;
            last_hs = s_cyc;
         end
      end
      n_vec++; if (first_vld - first_re !== 2) begin n_err++; $display("FAIL first_latency: got %0d, required 2", first_vld - first_re); end
      n_vec++; if (last_hs - first_hs !== 7) begin n_err++; $display("FAIL burst_span: got %0d, required 7", last_hs - first_hs); end
      n_vec++; if (n_out - o0 !== 8) begin n_err++; $display("FAIL burst_count: got %0d, required 8", n_out - o0); end
      drain("stream");
   endtask

   task automatic test_miss();
      int re_cyc[$];
      logic seen_vld = 1'b0;
      src_q.delete(); en = 1'b1; m_ready = 1'b1;
      for (int k = 0; k < 22; k++) begin
         cycle();
         if (s_re) re_cyc.push_back(s_cyc);
         if (s_vld) seen_vld = 1'b1;
      end
      n_vec++; if (re_cyc.size() !== 4) begin n_err++; $display("FAIL miss_pops: got %0d, required 4", re_cyc.size()); end
      for (int i = 1; i < re_cyc.size(); i++) begin
         n_vec++;
         if (re_cyc[i] - re_cyc[i-1] !== BACKOFF_CYC + 2) begin
            n_err++; $display("FAIL miss_gap: got %0d, required %0d", re_cyc[i] - re_cyc[i-1], BACKOFF_CYC + 2);
         end
      end
      n_vec++; if (seen_vld !== 1'b0) begin n_err++; $display("FAIL miss_valid: got %0b, required 0", seen_vld); end
`ifdef FIFO_RDR_STATS_EN
      n_vec++; if (miss_count < 16'd1) begin n_err++; $display("FAIL miss_count_min: got %0d, required >=1", miss_count); end
`endif
      drain("miss");
   endtask

   task automatic test_backpressure();
      int p0, o0;
      logic [DW-1:0] first;
      for (int i = 0; i < 5; i++) src_q.push_back($urandom);
      first = src_q[0];
      p0 = n_pop; m_ready = 1'b0; en = 1'b1;
      for (int k = 0; k < 8; k++) cycle();
      n_vec++; if (n_pop - p0 !== BUF_DEPTH) begin n_err++; $display("FAIL bp_pops: got %0d, required %0d", n_pop - p0, BUF_DEPTH); end
      n_vec++; if (s_re !== 1'b0) begin n_err++; $display("FAIL bp_re_held: got %0b, required 0", s_re); end
      n_vec++; if (s_vld !== 1'b1 || s_dat !== first) begin n_err++; $display("FAIL bp_head: valid=%0b data=%h, required 1 %h", s_vld, s_dat, first); end
      o0 = n_out; m_ready = 1'b1;
      for (int k = 0; k < 12; k++) cycle();
      n_vec++; if (n_out - o0 !== 5) begin n_err++; $display("FAIL bp_release: got %0d, required 5", n_out - o0); end
      drain("bp");
   endtask

   task automatic test_en_drop();
      int p0, o0;
      logic got = 1'b0, re_after = 1'b0;
      src_q.delete();
      for (int i = 0; i < 4; i++) src_q.push_back($urandom);
      o0 = n_out; m_ready = 1'b1; en = 1'b1;
      for (int k = 0; k < 10 && !got; k++) begin
         cycle();
         if (s_re) got = 1'b1;
      end
      n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL endrop_pop_seen: got %0b, required 1", got); end
      en = 1'b0; p0 = n_pop;
      for (int k = 0; k < 20; k++) begin
         cycle();
         if (s_re) re_after = 1'b1;
         if (!s_busy) break;
      end
      n_vec++; if (s_busy !== 1'b0) begin n_err++; $display("FAIL endrop_busy: got %0b, required 0", s_busy); end
      n_vec++; if (re_after !== 1'b0) begin n_err++; $display("FAIL endrop_re: got %0b, required 0", re_after); end
      n_vec++; if (n_out - o0 !== 1) begin n_err++; $display("FAIL endrop_words: got %0d, required 1", n_out - o0); end
      n_vec++; if (n_pop !== p0 || src_q.size() !== 3) begin n_err++; $display("FAIL endrop_left: got %0d, required 3", src_q.size()); end
      src_q.delete();
   endtask

   task automatic test_reset_mid();
      int o0;
      logic any_vld = 1'b0, any_re = 1'b0;
      for (int i = 0; i < 6; i++) src_q.push_back($urandom);
      m_ready = 1'b0; en = 1'b1;
      for (int k = 0; k < 6; k++) cycle();
      m_ready = 1'b1;
      cycle();
      rstn = 1'b0;
      #1;
      n_vec++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %0b, required 0", m_valid); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %0b, required 0", busy); end
      exp_q.delete(); p_stall = 1'b0; en = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      for (int k = 0; k < 8; k++) begin
         cycle();
         if (s_vld) any_vld = 1'b1;
         if (s_re) any_re = 1'b1;
      end
      n_vec++; if (any_vld !== 1'b0 || any_re !== 1'b0) begin n_err++; $display("FAIL rstmid_quiet: valid=%0b re=%0b, required 0 0", any_vld, any_re); end
      o0 = n_out; en = 1'b1;
      for (int k = 0; k < 15; k++) cycle();
      drain("rstmid");
      n_vec++; if (n_out - o0 !== 3) begin n_err++; $display("FAIL rstmid_resume: got %0d, required 3", n_out - o0); end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         m_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 15) == 0) en = ~en;
         if ($urandom_range(0, 7) == 0 && src_q.size() < 20)
            for (int j = $urandom_range(1, 4); j > 0; j--) src_q.push_back($urandom);
         n_vec++;
         if (exp_q.size() > BUF_DEPTH) begin n_err++; $display("FAIL rand_credit: held %0d, required <=%0d", exp_q.size(), BUF_DEPTH); end
         cycle();
      end
      src_q.delete();
      drain("rand");
      n_vec++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL rand_leftover: got %0d, required 0", exp_q.size()); end
   endtask

`ifdef FIFO_RDR_STATS_EN
   task automatic test_stats();
      int m0;
      src_q.delete(); en = 1'b0;
      hard_reset();
      for (int i = 0; i < 64; i++) src_q.push_back($urandom);
      m0 = n_miss; en = 1'b1; m_ready = 1'b1;
      for (int k = 0; k < 400 && (n_miss - m0) < 3; k++) cycle();
      en = 1'b0;
      drain("stats");
      n_vec++; if (rd_count !== 32'd64) begin n_err++; $display("FAIL stats_rd: got %0d, required 64", rd_count); end
      n_vec++; if (miss_count !== 16'd3) begin n_err++; $display("FAIL stats_miss: got %0d, required 3", miss_count); end
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_stream();
      test_miss();
      test_backpressure();
      test_en_drop();
      test_reset_mid();
      test_random();
`ifdef FIFO_RDR_STATS_EN
      test_stats();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
